render_sequencer: RTL and testbench

RENDER_SEQUENCER -- requirements
Module: render_sequencer

---
 rtl/render_sequencer_pkg.sv | 33 +++
 rtl/render_sequencer_fb_port_mux.sv | 49 ++++
 rtl/render_sequencer.sv | 160 ++++++++++++++++
 tb/tb_render_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : render_sequencer_pkg
//  Description : Shared constants and state encoding for the render sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package render_sequencer_pkg;

    // Frame-buffer geometry: 320x240 pixels of 24-bit colour.
    localparam int PIXEL_W       = 24;
    localparam int FRAME_SIZE    = 76800;
    localparam int FB_ADDR_W_DEF = $clog2(FRAME_SIZE);

    // Sequencer states: each drawer gets a KICK (start pulse), an ARM (wait
    // for the drawer to acknowledge by dropping done) and a RUN (wait for done).
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MAP_KICK = 3'd1,
        ST_MAP_ARM  = 3'd2,
        ST_MAP_RUN  = 3'd3,
        ST_SPR_KICK = 3'd4,
        ST_SPR_ARM  = 3'd5,
        ST_SPR_RUN  = 3'd6,
        ST_FINISH   = 3'd7
    } state_t;

    // One-hot grant codes for the frame-buffer port mux.
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_MAP  = 2'b01;
    localparam logic [1:0] GRANT_SPR  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/render_sequencer_fb_port_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fb_port_mux
//  Description : Two-requester frame-buffer write mux with one-hot grant.
//                Outputs are zero when nothing (or an illegal code) is granted.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_port_mux #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24
) (
    input  logic [1:0]        grant,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // Pass the granted requester straight through; anything else reads as idle.
    always_comb begin
        we   = 1'b0;
        addr = '0;
        data = '0;
        case (grant)
            2'b01: begin
                we   = req0_we;
                addr = req0_addr;
                data = req0_data;
            end
            2'b10: begin
                we   = req1_we;
                addr = req1_addr;
                data = req1_data;
            end
            default: begin
                we   = 1'b0;
                addr = '0;
                data = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/render_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : render_sequencer
//  Description : Per-frame sequencer: kicks the map drawer, then the sprite
//                drawer, arbitrating their frame-buffer writes, and counts
//                completed frames.
//                Optional watchdog enabled by defining RENDER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module render_sequencer
    import render_sequencer_pkg::*;
#(
    parameter int FB_ADDR_W      = FB_ADDR_W_DEF,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_go,
    output logic                 map_start,
    input  logic                 map_done,
    input  logic                 map_we,
    input  logic [FB_ADDR_W-1:0] map_addr,
    input  logic [PIXEL_W-1:0]   map_data,
    output logic                 spr_start,
    input  logic                 spr_done,
    input  logic                 spr_we,
    input  logic [FB_ADDR_W-1:0] spr_addr,
    input  logic [PIXEL_W-1:0]   spr_data,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [PIXEL_W-1:0]   fb_data,
    output logic                 busy,
    output logic [7:0]           frame_cnt
`ifdef RENDER_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] grant;
    logic       wd_expired;

`ifdef RENDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            in_phase;

    assign in_phase   = (state == ST_MAP_ARM) || (state == ST_MAP_RUN) ||
                        (state == ST_SPR_ARM) || (state == ST_SPR_RUN);
    assign wd_expired = in_phase && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: restarts on every kick, counts drawer-phase cycles, and latches
    // a sticky error when a phase is abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((state == ST_MAP_KICK) || (state == ST_SPR_KICK)) begin
                wd_cnt <= '0;
            end else if (in_phase) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_expired) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    // Without the watchdog the drawer phases wait indefinitely.
    assign wd_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, start pulses and grant selection; a watchdog expiry abandons
    // the current drawer and moves on as if it had finished.
    always_comb begin
        state_nxt = state;
        map_start = 1'b0;
        spr_start = 1'b0;
        grant     = GRANT_NONE;
        case (state)
            ST_IDLE: begin
                if (frame_go) state_nxt = ST_MAP_KICK;
            end
            ST_MAP_KICK: begin
                map_start = 1'b1;
                state_nxt = ST_MAP_ARM;
            end
            ST_MAP_ARM: begin
                grant = GRANT_MAP;
                if (wd_expired)     state_nxt = ST_SPR_KICK;
                else if (!map_done) state_nxt = ST_MAP_RUN;
            end
            ST_MAP_RUN: begin
                grant = GRANT_MAP;
                if (wd_expired || map_done) state_nxt = ST_SPR_KICK;
            end
            ST_SPR_KICK: begin
                spr_start = 1'b1;
                state_nxt = ST_SPR_ARM;
            end
            ST_SPR_ARM: begin
                grant = GRANT_SPR;
                if (wd_expired)     state_nxt = ST_FINISH;
                else if (!spr_done) state_nxt = ST_SPR_RUN;
            end
            ST_SPR_RUN: begin
                grant = GRANT_SPR;
                if (wd_expired || spr_done) state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Completed-frame counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (state == ST_FINISH) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign busy = (state != ST_IDLE);

    fb_port_mux #(
        .ADDR_W (FB_ADDR_W),
        .DATA_W (PIXEL_W)
    ) u_fb_port_mux (
        .grant     (grant),
        .req0_we   (map_we),
        .req0_addr (map_addr),
        .req0_data (map_data),
        .req1_we   (spr_we),
        .req1_addr (spr_addr),
        .req1_data (spr_data),
        .we        (fb_we),
        .addr      (fb_addr),
        .data      (fb_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_render_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_render_sequencer
//  Description : Self-checking bench for render_sequencer. Frame timing and
//                grant windows are derived from drawer busy lengths:
//                go accepted at edge 0, MAP_KICK in cycle 1, map phase of
//                n1+1 cycles, sprite phase of n2+1 cycles, FINISH, IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_render_sequencer;

    localparam int AW = 17;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_go = 1'b0;
    logic          map_start, spr_start;
    logic          map_done, spr_done;
    logic          map_we = 1'b0, spr_we = 1'b0;
    logic [AW-1:0] map_addr = '0, spr_addr = '0;
    logic [DW-1:0] map_data = '0, spr_data = '0;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_data;
    logic          busy;
    logic [7:0]    frame_cnt;
`ifdef RENDER_TIMEOUT_EN
    logic          timeout_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Drawer models: busy (done low) for n cycles after each start pulse.
    int   n_map = 1, n_spr = 1;
    int   map_cnt, spr_cnt;
    bit   map_hold = 1'b0;
    logic [7:0] model_cnt = 8'd0;

    render_sequencer #(
        .FB_ADDR_W      (AW),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_go  (frame_go),
        .map_start (map_start),
        .map_done  (map_done),
        .map_we    (map_we),
        .map_addr  (map_addr),
        .map_data  (map_data),
        .spr_start (spr_start),
        .spr_done  (spr_done),
        .spr_we    (spr_we),
        .spr_addr  (spr_addr),
        .spr_data  (spr_data),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .busy      (busy),
        .frame_cnt (frame_cnt)
`ifdef RENDER_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            map_cnt <= 0;
            spr_cnt <= 0;
        end else begin
            if (map_start)        map_cnt <= n_map;
            else if (map_cnt > 0) map_cnt <= map_cnt - 1;
            if (spr_start)        spr_cnt <= n_spr;
            else if (spr_cnt > 0) spr_cnt <= spr_cnt - 1;
        end
    end

    assign map_done = (map_cnt == 0) && !map_hold;
    assign spr_done = (spr_cnt == 0);

    task automatic do_reset();
        rst = 1'b1;
        frame_go = 1'b0;
        map_hold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_cnt = 8'd0;
    endtask

    // One frame with randomized drawer writes; go_at injects an extra frame_go
    // at that cycle index, force_spr keeps the sprite drawer writing 0x10.
    task automatic run_frame(input int n1, input int n2, input int go_at, input bit force_spr);
        bit            e_map, e_spr, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        n_map = n1;
        n_spr = n2;
        @(negedge clk);
        frame_go = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= n1 + n2 + 7; k++) begin
            frame_go = (k == go_at);
            map_we   = 1'($urandom_range(0, 1));
            map_addr = AW'($urandom);
            map_data = DW'($urandom);
            spr_we   = force_spr ? 1'b1 : 1'($urandom_range(0, 1));
            spr_addr = force_spr ? AW'(17'h00010) : AW'($urandom);
            spr_data = DW'($urandom);
            #1;
            e_map = (k >= 2) && (k <= n1 + 2);
            e_spr = (k >= n1 + 4) && (k <= n1 + n2 + 4);
            e_we   = e_map ? map_we   : (e_spr ? spr_we   : 1'b0);
            e_addr = e_map ? map_addr : (e_spr ? spr_addr : '0);
            e_data = e_map ? map_data : (e_spr ? spr_data : '0);
            n_tests += 5;
            if (map_start !== (k == 1)) begin
                n_fail++;
                $display("FAIL map_start k=%0d: got %b want %b", k, map_start, (k == 1));
            end
            if (spr_start !== (k == n1 + 3)) begin
                n_fail++;
                $display("FAIL spr_start k=%0d: got %b want %b", k, spr_start, (k == n1 + 3));
            end
            if (busy !== (k <= n1 + n2 + 5)) begin
                n_fail++;
                $display("FAIL busy k=%0d: got %b want %b", k, busy, (k <= n1 + n2 + 5));
            end
            if (fb_we !== e_we) begin
                n_fail++;
                $display("FAIL fb_we k=%0d: got %b want %b", k, fb_we, e_we);
            end
            if ({fb_addr, fb_data} !== {e_addr, e_data}) begin
                n_fail++;
                $display("FAIL fb_addr_data k=%0d: got %h/%h want %h/%h", k, fb_addr, fb_data, e_addr, e_data);
            end
            @(negedge clk);
        end
        frame_go = 1'b0;
        model_cnt = model_cnt + 8'd1;
        n_tests++;
        if (frame_cnt !== model_cnt) begin
            n_fail++;
            $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, model_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        map_we = 1'b1; map_addr = AW'(17'h1abcd); map_data = DW'(24'h123456);
        spr_we = 1'b1; spr_addr = AW'(17'h00010); spr_data = DW'(24'h654321);
        repeat (2) @(negedge clk);
        n_tests += 3;
        if ({busy, map_start, spr_start} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000", {busy, map_start, spr_start});
        end
        if ({fb_we, fb_addr, fb_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_fb: got %b/%h/%h want 0", fb_we, fb_addr, fb_data);
        end
        if (frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", frame_cnt);
        end
`ifdef RENDER_TIMEOUT_EN
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_timeout_err: got %b want 0", timeout_err);
        end
`endif
        rst = 1'b0;
        model_cnt = 8'd0;
    endtask

    task automatic test_basic_frame();
        run_frame(10, 5, 0, 1'b0);
    endtask

    task automatic test_grant_drop();
        run_frame(6, 3, 0, 1'b1);
    endtask

    task automatic test_ignore_go();
        int n1, n2;
        for (int i = 0; i < 6; i++) begin
            n1 = $urandom_range(1, 20);
            n2 = $urandom_range(1, 20);
            run_frame(n1, n2, $urandom_range(n1 + 5, n1 + n2 + 4), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_frame($urandom_range(1, 3), $urandom_range(1, 3), 0, 1'b0);
        end
        n_tests++;
        if (frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap: got %0d want 0", frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        n_map = 10;
        n_spr = 5;
        @(negedge clk);
        frame_go = 1'b1;
        @(negedge clk);
        frame_go = 1'b0;
        repeat (4) @(negedge clk);
        map_we = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, fb_we} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_async: got busy/we %b want 00", {busy, fb_we});
        end
        @(negedge clk);
        n_tests++;
        if ({busy, fb_we, frame_cnt} !== 10'd0) begin
            n_fail++;
            $display("FAIL abort: got busy=%b we=%b cnt=%0d want 0/0/0", busy, fb_we, frame_cnt);
        end
        rst = 1'b0;
        model_cnt = 8'd0;
        run_frame(4, 4, 0, 1'b0);
    endtask

`ifdef RENDER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        map_hold = 1'b1;
        n_spr = 4;
        @(negedge clk);
        frame_go = 1'b1;
        @(negedge clk);
        frame_go = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            #1;
            n_tests += 3;
            if (spr_start !== (k == 52)) begin
                n_fail++;
                $display("FAIL to_spr_start k=%0d: got %b want %b", k, spr_start, (k == 52));
            end
            if (timeout_err !== (k >= 52)) begin
                n_fail++;
                $display("FAIL timeout_err k=%0d: got %b want %b", k, timeout_err, (k >= 52));
            end
            if (busy !== (k <= 58)) begin
                n_fail++;
                $display("FAIL to_busy k=%0d: got %b want %b", k, busy, (k <= 58));
            end
            @(negedge clk);
        end
        map_hold = 1'b0;
        n_tests++;
        if (frame_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL to_frame_cnt: got %0d want 1", frame_cnt);
        end
        model_cnt = 8'd1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_grant_drop();
        test_ignore_go();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef RENDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
